ov7670_frame_writer: RTL and testbench
======================================

Name: ov7670_frame_writer

Overview:
Downstream consumer of the OV7670 byte-capture stage. Pairs captured bytes into RGB565 pixels in the camera pixel-clock domain, then reduces them to RGB444. Carries the pixels across to the system clock domain through an asynchronous FIFO with Gray-coded pointers. Produces a linear, single-port write stream into the on-chip frame buffer BRAM, one 12-bit word per pixel.

Parameters:
H_RES, 320, active pixels per line
V_RES, 240, active lines per frame
ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES
FIFO_AW, 4, FIFO address width (depth 2^FIFO_AW entries of 13 bits)

Ports:
clk  in  1  system clock (100 MHz), frame-buffer side
rst_n  in  1  asynchronous active-low reset, applies to both domains
pclk  in  1  camera pixel clock, capture side
in_data  in  8  captured byte (pclk domain)
in_valid  in  1  byte strobe (pclk domain)
in_frame_valid  in  1  high during an active frame (pclk domain)
capture_en  in  1  clk domain; enables storing of the next frame
fb_we  out  1  frame-buffer write enable, one clk per pixel
fb_addr  out  ADDR_W  frame-buffer write address
fb_wdata  out  12  pixel {R[3:0],G[3:0],B[3:0]}
frame_done  out  1  one-clk pulse on the write of the last pixel of a frame
frame_count  out  8  completed frames, wraps 255->0
overflow  out  1  sticky, clk domain; a pixel was dropped on FIFO full

Behaviour:
- Reset: rst_n is asynchronous, active-low, and applies to both domains. Outputs reset to fb_we=0, fb_addr=0, fb_wdata=0, frame_done=0, frame_count=0, overflow=0. FIFO pointers, byte phase, armed and pending_sof all clear. Asserting reset mid-frame discards the FIFO contents; the next write after reset requires a new frame start.
- pclk domain, enable: capture_en passes through a 2-FF synchronizer into pclk. On the rising edge of in_frame_valid (registered compare): armed <= capture_en_sync and pending_sof <= 1. armed holds for the whole frame, so enable is frame-granular.
- Byte pairing:
  - phase=0 with in_valid: latch hi byte, phase<=1.
  - phase=1 with in_valid: form {hi,in_data} as RGB565, phase<=0.
  - phase<=0 whenever in_valid=0 or in_frame_valid=0, so an odd byte count per line drops the trailing byte.
- Conversion: R=p[15:12], G=p[10:7], B=p[4:1].
- Push: a completed pixel is pushed only if armed. The FIFO entry is {sof,rgb444}, with sof=pending_sof; pending_sof clears on push.
- Push when full: the pixel is dropped and an overflow toggle flips. The toggle is synchronized to clk, and overflow sets on each detected change.
- FIFO: binary plus Gray pointers, with 2-FF synchronizers in each direction.
  - full = wr_gray == {~rd_gray_sync[MSB:MSB-1], rd_gray_sync[rest]}.
  - empty = rd_gray == wr_gray_sync.
- clk domain pop: pop one entry per clk while not empty. fb_we asserts on the clk after the pop, with fb_wdata registered.
- Addressing:
  - Entry with sof=1: fb_addr=0.
  - Entry with sof=0: fb_addr=previous+1.
  - No write has yet occurred since reset and sof=0: discard the entry (fb_we stays 0).
  - Previous address = H_RES*V_RES-1 and sof=0: discard (no wrap, no write) until the next sof.
- frame_done pulses in the same cycle as the fb_we at address H_RES*V_RES-1, and frame_count increments in that cycle.
- A short frame, where sof arrives before the last address, restarts at 0 with no frame_done.
- Latency: from the pclk edge sampling the second byte, fb_we follows within 3 pclk plus 4 clk cycles.
- Throughput: sustained 1 pixel per 2 pclk with clk >= pclk never overflows.

Test Plan:
- Small config: H_RES=4, V_RES=2, capture_en=1, pclk=24 MHz, one frame of 16 bytes (0xF8,0x00 repeated) -> 8 writes at addrs 0..7, all fb_wdata=0xF00. frame_done pulses once, at addr 7; frame_count=1; overflow=0.
- Byte pair 0x07,0xE0 -> 0x0F0; pair 0x00,0x1F -> 0x00F. A line with 5 bytes yields 2 pixels and the fifth byte is dropped.
- capture_en=0 at frame start, then raised mid-frame -> zero writes that frame. Writes begin at addr 0 on the next frame.
- Extra pixels beyond H_RES*V_RES in a frame -> no write past addr 7, exactly one frame_done. Next frame restarts at addr 0.
- clk slowed to 10 MHz with pclk at 24 MHz over a long frame -> overflow=1 and stays 1, no X on outputs, fb_addr never exceeds 7.
- rst_n pulsed low mid-frame -> all outputs 0 immediately (asynchronous). Remaining bytes of that frame produce no writes; the next frame writes from addr 0.

Source files
------------

// File: rtl/ov7670_frame_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : ov7670_frame_writer_if
// Brief    : Frame-buffer write bus produced by ov7670_frame_writer.
//            master = pixel writer, slave = frame-buffer BRAM port.
// Revision : 1.0 - initial release
// ============================================================================
interface ov7670_frame_writer_if #(
   parameter int ADDR_W = 17
);
   logic              fb_we;
   logic [ADDR_W-1:0] fb_addr;
   logic [11:0]       fb_wdata;
   logic              frame_done;

   modport master (
      output fb_we,
      output fb_addr,
      output fb_wdata,
      output frame_done
   );

   modport slave (
      input fb_we,
      input fb_addr,
      input fb_wdata,
      input frame_done
   );
endinterface
`default_nettype wire

// File: rtl/ov7670_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : ov7670_frame_writer
// Brief    : Pairs OV7670 capture bytes into RGB565 pixels (pclk domain),
//            reduces them to RGB444, crosses them into the system clock
//            through a Gray-pointer async FIFO and writes them linearly into
//            the frame buffer, one 12-bit word per pixel.
// Revision : 1.0 - initial release
// ============================================================================
module ov7670_frame_writer #(
   parameter int H_RES   = 320,
   parameter int V_RES   = 240,
   parameter int ADDR_W  = 17,
   parameter int FIFO_AW = 4
) (
   input  wire                   clk,
   input  wire                   rst_n,
   input  wire                   pclk,
   input  wire  [7:0]            in_data,
   input  wire                   in_valid,
   input  wire                   in_frame_valid,
   input  wire                   capture_en,
   ov7670_frame_writer_if.master fb,
   output logic [7:0]            frame_count,
   output logic                  overflow
);

   localparam int                c_PW    = FIFO_AW + 1;
   localparam int                c_DEPTH = 1 << FIFO_AW;
   localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(H_RES * V_RES - 1);

   // ------------------------------------------------------------------------
   // pclk domain
   // ------------------------------------------------------------------------
   logic [1:0]      r_cen_sync;
   logic            r_fv_d;
   logic            r_armed;
   logic            r_pend_sof;
   logic            r_phase;
   logic [7:0]      r_hi;
   logic [c_PW-1:0] r_wr_bin;
   logic [c_PW-1:0] r_wr_gray;
   logic [c_PW-1:0] r_rd_gray_s1;
   logic [c_PW-1:0] r_rd_gray_s2;
   logic            r_ovf_tgl;
   logic [12:0]     r_mem [c_DEPTH];

   logic            w_fv_rise;
   logic            w_pix_done;
   logic [15:0]     w_pix565;
   logic [11:0]     w_rgb444;
   logic            w_full;
   logic            w_push;
   logic            w_drop;
   logic [c_PW-1:0] w_wr_bin_nxt;

   // ------------------------------------------------------------------------
   // clk domain
   // ------------------------------------------------------------------------
   logic [c_PW-1:0]   r_rd_bin;
   logic [c_PW-1:0]   r_rd_gray;
   logic [c_PW-1:0]   r_wr_gray_s1;
   logic [c_PW-1:0]   r_wr_gray_s2;
   logic [2:0]        r_ovf_sync;
   logic              r_overflow;
   logic              r_fb_we;
   logic [ADDR_W-1:0] r_fb_addr;
   logic [11:0]       r_fb_wdata;
   logic              r_frame_done;
   logic [7:0]        r_frame_count;
   logic              r_wrote;

   logic              w_empty;
   logic              w_pop;
   logic [12:0]       w_entry;
   logic [c_PW-1:0]   w_rd_bin_nxt;
   logic              w_wr_en;
   logic [ADDR_W-1:0] w_wr_addr;

   // Frame start is the rising edge of in_frame_valid against its registered copy
   assign w_fv_rise    = in_frame_valid & ~r_fv_d;
   assign w_pix_done   = in_valid & in_frame_valid & r_phase;
   assign w_pix565     = {r_hi, in_data};
   assign w_rgb444     = {w_pix565[15:12], w_pix565[10:7], w_pix565[4:1]};
   // Full: write pointer one lap ahead of the synchronized read pointer
   assign w_full       = (r_wr_gray == {~r_rd_gray_s2[c_PW-1 -: 2], r_rd_gray_s2[c_PW-3:0]});
   assign w_push       = w_pix_done & r_armed & ~w_full;
   assign w_drop       = w_pix_done & r_armed &  w_full;
   assign w_wr_bin_nxt = r_wr_bin + c_PW'(1);

   // Synchronize capture_en and the FIFO read pointer into pclk
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_cen_sync   <= '0;
         r_rd_gray_s1 <= '0;
         r_rd_gray_s2 <= '0;
      end else begin
         r_cen_sync   <= {r_cen_sync[0], capture_en};
         r_rd_gray_s1 <= r_rd_gray;
         r_rd_gray_s2 <= r_rd_gray_s1;
      end
   end

   // Frame-granular arming and start-of-frame marker for the first pushed pixel.
   // r_fv_d resets high so a reset released mid-frame never sees a fake frame start.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_fv_d     <= 1'b1;
         r_armed    <= 1'b0;
         r_pend_sof <= 1'b0;
      end else begin
         r_fv_d <= in_frame_valid;
         if (w_fv_rise) begin
            r_armed    <= r_cen_sync[1];
            r_pend_sof <= 1'b1;
         end else if (w_push) begin
            r_pend_sof <= 1'b0;
         end
      end
   end

   // Byte pairing: any gap in in_valid/in_frame_valid restarts at the hi byte
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase <= 1'b0;
         r_hi    <= '0;
      end else if (!in_valid || !in_frame_valid) begin
         r_phase <= 1'b0;
      end else begin
         r_phase <= ~r_phase;
         if (!r_phase) begin
            r_hi <= in_data;
         end
      end
   end

   // Write pointer advance on push; a dropped pixel flips the overflow toggle
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_bin  <= '0;
         r_wr_gray <= '0;
         r_ovf_tgl <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_bin  <= w_wr_bin_nxt;
            r_wr_gray <= w_wr_bin_nxt ^ (w_wr_bin_nxt >> 1);
         end
         if (w_drop) begin
            r_ovf_tgl <= ~r_ovf_tgl;
         end
      end
   end

   // FIFO storage: {sof, rgb444}; contents are don't-care until a push
   always_ff @(posedge pclk) begin
      if (w_push) begin
         r_mem[r_wr_bin[FIFO_AW-1:0]] <= {r_pend_sof, w_rgb444};
      end
   end

   assign w_empty      = (r_rd_gray == r_wr_gray_s2);
   assign w_pop        = ~w_empty;
   assign w_entry      = r_mem[r_rd_bin[FIFO_AW-1:0]];
   assign w_rd_bin_nxt = r_rd_bin + c_PW'(1);

   // Synchronize the write pointer and overflow toggle into clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_gray_s1 <= '0;
         r_wr_gray_s2 <= '0;
         r_ovf_sync   <= '0;
      end else begin
         r_wr_gray_s1 <= r_wr_gray;
         r_wr_gray_s2 <= r_wr_gray_s1;
         r_ovf_sync   <= {r_ovf_sync[1:0], r_ovf_tgl};
      end
   end

   // Read pointer: one pop per clk while the FIFO holds data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_bin  <= '0;
         r_rd_gray <= '0;
      end else if (w_pop) begin
         r_rd_bin  <= w_rd_bin_nxt;
         r_rd_gray <= w_rd_bin_nxt ^ (w_rd_bin_nxt >> 1);
      end
   end

   // Sticky overflow: set on every observed toggle change
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow <= 1'b0;
      end else if (r_ovf_sync[2] != r_ovf_sync[1]) begin
         r_overflow <= 1'b1;
      end
   end

   // Address decision for the popped entry: sof restarts at 0, otherwise
   // continue linearly; stray pixels before any frame or past the end are discarded
   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_addr = r_fb_addr + ADDR_W'(1);
      if (w_pop) begin
         if (w_entry[12]) begin
            w_wr_en   = 1'b1;
            w_wr_addr = '0;
         end else if (r_wrote && (r_fb_addr != c_LAST)) begin
            w_wr_en   = 1'b1;
         end
      end
   end

   // Registered frame-buffer write port, end-of-frame pulse and frame counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fb_we       <= 1'b0;
         r_fb_addr     <= '0;
         r_fb_wdata    <= '0;
         r_frame_done  <= 1'b0;
         r_frame_count <= '0;
         r_wrote       <= 1'b0;
      end else begin
         r_fb_we      <= 1'b0;
         r_frame_done <= 1'b0;
         if (w_wr_en) begin
            r_fb_we    <= 1'b1;
            r_fb_addr  <= w_wr_addr;
            r_fb_wdata <= w_entry[11:0];
            r_wrote    <= 1'b1;
            if (w_wr_addr == c_LAST) begin
               r_frame_done  <= 1'b1;
               r_frame_count <= r_frame_count + 8'd1;
            end
         end
      end
   end

   assign fb.fb_we      = r_fb_we;
   assign fb.fb_addr    = r_fb_addr;
   assign fb.fb_wdata   = r_fb_wdata;
   assign fb.frame_done = r_frame_done;
   assign frame_count   = r_frame_count;
   assign overflow      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ov7670_frame_writer
// Brief    : Self-checking bench for ov7670_frame_writer (4x2 frame config).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ov7670_frame_writer;

   localparam int H_RES   = 4;
   localparam int V_RES   = 2;
   localparam int ADDR_W  = 17;
   localparam int FIFO_AW = 4;
   localparam int NPIX    = H_RES * V_RES;

   logic       clk   = 1'b0;
   logic       pclk  = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_frame_valid;
   logic       capture_en;
   logic [7:0] frame_count;
   logic       overflow;
   int         clk_half = 5;

   ov7670_frame_writer_if #(.ADDR_W(ADDR_W)) fb_bus ();

   ov7670_frame_writer #(
      .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W), .FIFO_AW(FIFO_AW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pclk(pclk),
      .in_data(in_data), .in_valid(in_valid), .in_frame_valid(in_frame_valid),
      .capture_en(capture_en), .fb(fb_bus),
      .frame_count(frame_count), .overflow(overflow)
   );

   always #(clk_half) clk = ~clk;
   always #21 pclk = ~pclk;

   typedef struct { int addr; int data; int done; } wr_t;
   typedef struct { logic [7:0] hi; logic [7:0] lo; logic [11:0] exp; } vec_t;

   wr_t        act_q[$];
   wr_t        exp_q[$];
   logic [7:0] fr_bytes[$];
   int         fr_len[$];
   vec_t       tbl[8];
   int         n_vec = 0;
   int         n_err = 0;
   int         model_fc = 0;
   int         done_cnt = 0;
   int         max_addr = 0;
   bit         x_seen = 0;

   // Write monitor, sampled away from the rising edge
   always @(negedge clk) begin
      if ($isunknown({fb_bus.fb_we, fb_bus.fb_addr, fb_bus.fb_wdata,
                      fb_bus.frame_done, frame_count, overflow}))
         x_seen = 1;
      if (fb_bus.fb_we === 1'b1) begin
         act_q.push_back('{int'(fb_bus.fb_addr), int'(fb_bus.fb_wdata), int'(fb_bus.frame_done)});
         if (int'(fb_bus.fb_addr) > max_addr) max_addr = int'(fb_bus.fb_addr);
      end
      if (fb_bus.frame_done === 1'b1) done_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, ".fb_we"},       32'(fb_bus.fb_we),      0);
      chk({tag, ".fb_addr"},     32'(fb_bus.fb_addr),    0);
      chk({tag, ".fb_wdata"},    32'(fb_bus.fb_wdata),   0);
      chk({tag, ".frame_done"},  32'(fb_bus.frame_done), 0);
      chk({tag, ".frame_count"}, 32'(frame_count),       0);
      chk({tag, ".overflow"},    32'(overflow),          0);
   endtask

   // Plays the frame held in fr_bytes/fr_len: contiguous bytes per line
   task automatic send_frame();
      int k = 0;
      @(negedge pclk);
      in_frame_valid = 1'b1;
      repeat (3) @(negedge pclk);
      foreach (fr_len[l]) begin
         for (int j = 0; j < fr_len[l]; j++) begin
            in_valid = 1'b1;
            in_data  = fr_bytes[k];
            k++;
            @(negedge pclk);
         end
         in_valid = 1'b0;
         in_data  = 8'h00;
         repeat (3) @(negedge pclk);
      end
      in_frame_valid = 1'b0;
      repeat (4) @(negedge pclk);
   endtask

   task automatic drain();
      repeat (4) @(negedge pclk);
      repeat (30) @(negedge clk);
   endtask

   // Reference: pixels are byte pairs within a line; an armed frame writes its
   // first NPIX pixels to addresses 0..NPIX-1, the last one flagged done
   task automatic build_expected(input bit armed);
      int k = 0;
      int n = 0;
      logic [15:0] p;
      exp_q.delete();
      foreach (fr_len[l]) begin
         for (int j = 0; j < fr_len[l]; j++) begin
            if (armed && (j % 2 == 1)) begin
               p = {fr_bytes[k-1], fr_bytes[k]};
               if (n < NPIX)
                  exp_q.push_back('{n, int'({p[15:12], p[10:7], p[4:1]}), int'(n == NPIX - 1)});
               n++;
            end
            k++;
         end
      end
      if (n >= NPIX) model_fc++;
   endtask

   task automatic compare_frame(input string name);
      int exp_done = 0;
      chk({name, ".nwrites"}, act_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         exp_done += exp_q[i].done;
         if (i < act_q.size()) begin
            chk($sformatf("%s.addr[%0d]", name, i), act_q[i].addr, exp_q[i].addr);
            chk($sformatf("%s.data[%0d]", name, i), act_q[i].data, exp_q[i].data);
            chk($sformatf("%s.done[%0d]", name, i), act_q[i].done, exp_q[i].done);
         end
      end
      chk({name, ".done_pulses"}, done_cnt, exp_done);
      chk({name, ".frame_count"}, 32'(frame_count), model_fc & 255);
   endtask

   task automatic set_enable(input bit en);
      capture_en = en;
      repeat (4) @(negedge pclk);
   endtask

   task automatic run_frame(input string name, input bit armed);
      set_enable(armed);
      act_q.delete();
      done_cnt = 0;
      send_frame();
      drain();
      build_expected(armed);
      compare_frame(name);
   endtask

   task automatic random_bytes(input int nlines, input int len);
      fr_bytes.delete();
      fr_len.delete();
      for (int l = 0; l < nlines; l++) begin
         fr_len.push_back(len);
         for (int j = 0; j < len; j++) fr_bytes.push_back(8'($urandom));
      end
   endtask

   initial begin
      in_data = 8'h00; in_valid = 1'b0; in_frame_valid = 1'b0; capture_en = 1'b0;

      tbl[0] = '{8'hF8, 8'h00, 12'hF00};
      tbl[1] = '{8'h07, 8'hE0, 12'h0F0};
      tbl[2] = '{8'h00, 8'h1F, 12'h00F};
      tbl[3] = '{8'hFF, 8'hFF, 12'hFFF};
      tbl[4] = '{8'hA5, 8'h5A, 12'hAAD};
      tbl[5] = '{8'h80, 8'h01, 12'h800};
      tbl[6] = '{8'h03, 8'h80, 12'h070};
      tbl[7] = '{8'h00, 8'h10, 12'h008};

      repeat (3) @(negedge clk);
      chk_outputs_zero("reset");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Table-driven conversion frame: two lines of four pixels
      set_enable(1'b1);
      fr_bytes.delete();
      fr_len.delete();
      for (int i = 0; i < 8; i++) begin
         fr_bytes.push_back(tbl[i].hi);
         fr_bytes.push_back(tbl[i].lo);
      end
      fr_len.push_back(8);
      fr_len.push_back(8);
      act_q.delete();
      done_cnt = 0;
      send_frame();
      drain();
      model_fc = 1;
      chk("table.nwrites", act_q.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < act_q.size()) begin
            chk($sformatf("table.addr[%0d]", i), act_q[i].addr, i);
            chk($sformatf("table.data[%0d]", i), act_q[i].data, int'(tbl[i].exp));
            chk($sformatf("table.done[%0d]", i), act_q[i].done, int'(i == 7));
         end
      end
      chk("table.done_pulses", done_cnt, 1);
      chk("table.frame_count", 32'(frame_count), 1);
      chk("table.overflow", 32'(overflow), 0);

      // Odd line length: trailing fifth byte dropped
      fr_bytes.delete();
      fr_len.delete();
      fr_bytes = '{8'h07, 8'hE0, 8'h00, 8'h1F, 8'hAA};
      fr_len.push_back(5);
      for (int j = 0; j < 12; j++) fr_bytes.push_back(8'($urandom));
      fr_len.push_back(12);
      run_frame("odd_line", 1'b1);

      // Enable raised mid-frame: nothing that frame, writes from 0 on the next
      random_bytes(2, 8);
      set_enable(1'b0);
      act_q.delete();
      done_cnt = 0;
      fork
         send_frame();
         begin
            repeat (8) @(negedge pclk);
            capture_en = 1'b1;
         end
      join
      drain();
      build_expected(1'b0);
      compare_frame("late_enable");
      run_frame("after_late_enable", 1'b1);

      // Extra pixels beyond the frame, then a short frame
      random_bytes(3, 8);
      run_frame("extra_pixels", 1'b1);
      random_bytes(1, 8);
      run_frame("short_frame", 1'b1);

      // Randomized frames
      for (int f = 0; f < 10; f++) begin
         bit armed;
         int nl;
         armed = 1'($urandom_range(0, 1));
         nl = $urandom_range(1, 4);
         fr_bytes.delete();
         fr_len.delete();
         for (int l = 0; l < nl; l++) begin
            int len;
            len = $urandom_range(0, 12);
            fr_len.push_back(len);
            for (int j = 0; j < len; j++) fr_bytes.push_back(8'($urandom));
         end
         run_frame($sformatf("rand%0d", f), armed);
      end

      // Asynchronous reset mid-frame
      random_bytes(3, 8);
      set_enable(1'b1);
      act_q.delete();
      done_cnt = 0;
      fork
         send_frame();
         begin
            repeat (10) @(negedge pclk);
            @(negedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            chk_outputs_zero("async_rst");
            act_q.delete();
            done_cnt = 0;
            model_fc = 0;
            #30;
            rst_n = 1'b1;
         end
      join
      drain();
      chk("async_rst.rest_of_frame_writes", act_q.size(), 0);
      random_bytes(2, 8);
      run_frame("post_reset", 1'b1);

      // Slow system clock: overflow becomes sticky, no writes past the end
      clk_half = 50;
      repeat (4) @(negedge clk);
      random_bytes(5, 120);
      act_q.delete();
      done_cnt = 0;
      max_addr = 0;
      x_seen = 0;
      send_frame();
      drain();
      model_fc++;
      chk("ovf.overflow", 32'(overflow), 1);
      chk("ovf.nwrites", act_q.size(), NPIX);
      chk("ovf.done_pulses", done_cnt, 1);
      chk("ovf.addr_in_range", 32'(max_addr <= NPIX - 1), 1);
      chk("ovf.no_x", 32'(x_seen), 0);
      chk("ovf.frame_count", 32'(frame_count), model_fc & 255);
      clk_half = 5;
      repeat (4) @(negedge clk);
      random_bytes(2, 8);
      run_frame("post_overflow", 1'b1);
      chk("post_overflow.sticky", 32'(overflow), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
